// File: rtl/trng_pkg.sv
// Shared types and constants for the metastable-cell sampling controller.
// Strobe encoding helper keeps the FSM output table in one place.
package trng_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_RES,
    S_CAP,
    S_HOLD
  } state_t;

  localparam int WIDTH_DEF     = 8;
  localparam int T_PRE_DEF     = 4;
  localparam int T_RES_DEF     = 4;
  localparam int REP_LIMIT_DEF = 16;
  localparam int CAP_LEN       = 3;

  // {en_samp_in0, en_samp_in1, en_samp_out}
  function automatic logic [2:0] strobes(state_t s);
    unique case (s)
      S_PRE:   return 3'b110;
      S_CAP:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/trng_sample_ctrl_if.sv
// Word delivery port of the sampling controller.
// Producer drives data/valid, consumer drives ready.
interface trng_sample_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann pair debiaser plus repetition-count health test.
// Outputs are combinational on the raw strobe so the FSM can act the same cycle.
module trng_vn_debias
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic db_bit,
  output logic db_valid,
  output logic rep_fail
);

  localparam int RW = $clog2(REP_LIMIT + 1);

  logic          r_have_a;
  logic          r_a;
  logic          r_last;
  logic [RW-1:0] r_rep;
  logic          w_same;

  assign w_same   = (r_rep != '0) && (raw_bit == r_last);
  assign db_bit   = r_a;
  assign db_valid = raw_valid && r_have_a && (r_a != raw_bit);
  assign rep_fail = raw_valid && w_same &&
                    (r_rep >= RW'(REP_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_have_a <= 1'b0;
      r_a      <= 1'b0;
      r_last   <= 1'b0;
      r_rep    <= '0;
    end else if (raw_valid) begin
      r_last   <= raw_bit;
      r_have_a <= !r_have_a;
      if (!r_have_a)
        r_a <= raw_bit;
      if (!w_same)
        r_rep <= RW'(1);
      else if (r_rep != RW'(REP_LIMIT))
        r_rep <= r_rep + 1'b1;
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// Precharge/resolve/capture sequencer for the entropy cell.
// Synchronizes the cell output, packs debiased bits, delivers words.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int T_PRE     = T_PRE_DEF,
  parameter int T_RES     = T_RES_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ent_bit,
  output logic en_samp_in0,
  output logic en_samp_in1,
  output logic en_samp_out,
  output logic health_fail,
  output logic busy,
  trng_sample_ctrl_if.master dp
);

  localparam int CM1 = (T_PRE > T_RES) ? T_PRE : T_RES;
  localparam int CM2 = (CM1 > CAP_LEN) ? CM1 : CAP_LEN;
  localparam int CW  = $clog2(CM2 + 1);
  localparam int BW  = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_s1;
  logic             r_s2;
  logic             r_in0;
  logic             r_in1;
  logic             r_sout;
  logic             r_hf;
  logic             r_held;
  logic             r_valid;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_out;
  logic [BW-1:0]    r_bcnt;

  logic             w_raw_valid;
  logic             w_db_bit;
  logic             w_db_valid;
  logic             w_rep_fail;
  logic             w_hs;
  logic             w_last;
  logic             w_go;
  state_t           w_nxt;
  logic [WIDTH-1:0] w_word;

  trng_vn_debias #(
    .REP_LIMIT (REP_LIMIT)
  ) u_db (
    .clk       (clk),
    .rst       (rst),
    .raw_bit   (r_s2),
    .raw_valid (w_raw_valid),
    .db_bit    (w_db_bit),
    .db_valid  (w_db_valid),
    .rep_fail  (w_rep_fail)
  );

  assign w_raw_valid = (r_state == S_CAP) &&
                       (r_cnt == CW'(CAP_LEN - 1));
  assign w_hs   = r_valid && dp.data_ready;
  assign w_last = (r_bcnt == BW'(WIDTH - 1));
  assign w_go   = run && !r_hf;
  assign w_nxt  = w_go ? S_PRE : S_IDLE;
  assign w_word = r_sr |
    ({{(WIDTH-1){1'b0}}, w_db_bit} << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_in0   <= 1'b0;
      r_in1   <= 1'b0;
      r_sout  <= 1'b0;
      r_hf    <= 1'b0;
      r_held  <= 1'b0;
      r_valid <= 1'b0;
      r_sr    <= '0;
      r_out   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_s1 <= ent_bit;
      r_s2 <= r_s1;
      if (w_hs)
        r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go && !r_held) begin
            r_state <= S_PRE;
            r_cnt   <= '0;
            {r_in0, r_in1, r_sout} <= strobes(S_PRE);
          end
        end
        S_PRE: begin
          if (r_cnt == CW'(T_PRE - 1)) begin
            r_state <= S_RES;
            r_cnt   <= '0;
            {r_in0, r_in1, r_sout} <= strobes(S_RES);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RES: begin
          if (r_cnt == CW'(T_RES - 1)) begin
            r_state <= S_CAP;
            r_cnt   <= '0;
            {r_in0, r_in1, r_sout} <= strobes(S_CAP);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAP: begin
          if (!w_raw_valid) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_rep_fail) begin
            // Failure drops the partial word and parks the FSM for good
            r_hf    <= 1'b1;
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            {r_in0, r_in1, r_sout} <= strobes(S_IDLE);
          end else if (w_db_valid && w_last) begin
            r_bcnt <= '0;
            r_cnt  <= '0;
            if (!r_valid || w_hs) begin
              r_out   <= w_word;
              r_valid <= 1'b1;
              r_sr    <= '0;
              r_state <= w_nxt;
              {r_in0, r_in1, r_sout} <= strobes(w_nxt);
            end else begin
              r_held  <= 1'b1;
              r_sr    <= w_word;
              r_state <= S_HOLD;
              {r_in0, r_in1, r_sout} <= strobes(S_HOLD);
            end
          end else begin
            if (w_db_valid) begin
              r_sr[r_bcnt] <= w_db_bit;
              r_bcnt       <= r_bcnt + 1'b1;
            end
            r_cnt   <= '0;
            r_state <= w_nxt;
            {r_in0, r_in1, r_sout} <= strobes(w_nxt);
          end
        end
        S_HOLD: begin
          if (w_hs) begin
            r_out   <= r_sr;
            r_valid <= 1'b1;
            r_sr    <= '0;
            r_held  <= 1'b0;
            r_cnt   <= '0;
            r_state <= w_nxt;
            {r_in0, r_in1, r_sout} <= strobes(w_nxt);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          {r_in0, r_in1, r_sout} <= 3'b000;
        end
      endcase
    end
  end

  assign en_samp_in0   = r_in0;
  assign en_samp_in1   = r_in1;
  assign en_samp_out   = r_sout;
  assign health_fail   = r_hf;
  assign busy          = (r_state != S_IDLE);
  assign dp.data_out   = r_out;
  assign dp.data_valid = r_valid;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Scoreboard bench: raw-bit driver feeds a pair/pack/health model,
// a monitor pops expected words on every handshake.
module tb_trng_sample_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic ent_bit;
  logic in0;
  logic in1;
  logic sout;
  logic hf;
  logic busy;

  trng_sample_ctrl_if #(.WIDTH(8)) dp ();

  trng_sample_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ent_bit     (ent_bit),
    .en_samp_in0 (in0),
    .en_samp_in1 (in1),
    .en_samp_out (sout),
    .health_fail (hf),
    .busy        (busy),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int raw_cnt = 0;
  int valid_cycles = 0;
  int strobe_cycles = 0;
  int hs_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  bit script_q[$];

  logic [7:0] exp_q[$];
  bit m_prev;
  int m_run;
  bit m_fail;
  bit m_has_a;
  bit m_a;
  bit m_bits[$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_bits.delete();
    m_run   = 0;
    m_fail  = 0;
    m_has_a = 0;
  endfunction

  // Reference: run-length health test, then pair rule, then LSB-first packing
  function automatic void model_raw(bit b);
    logic [7:0] w;
    m_run  = (m_run > 0 && b == m_prev) ? m_run + 1 : 1;
    m_prev = b;
    if (m_fail) return;
    if (m_run >= 16) begin
      m_fail = 1;
      m_bits.delete();
      return;
    end
    if (!m_has_a) begin
      m_a = b;
      m_has_a = 1;
    end else begin
      m_has_a = 0;
      if (m_a != b) begin
        m_bits.push_back(m_a);
        if (m_bits.size() == 8) begin
          w = 8'h00;
          foreach (m_bits[k]) w[k] = m_bits[k];
          exp_q.push_back(w);
          m_bits.delete();
        end
      end
    end
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_aa();
    repeat (4) begin
      script_q.push_back(1'b0);
      script_q.push_back(1'b1);
      script_q.push_back(1'b1);
      script_q.push_back(1'b0);
    end
  endtask

  // Raw-bit driver: new bit at start of each precharge, stable through capture
  initial begin
    bit p;
    bit b;
    bit dprev;
    int dr;
    p = 0; dprev = 0; dr = 0;
    ent_bit = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (in0 && !p && !rst) begin
        if (script_q.size() > 0) begin
          b = script_q.pop_front();
        end else begin
          b = 1'($urandom % 2);
          if (dr >= 6 && b == dprev) b = ~b;
        end
        dr = (b == dprev) ? dr + 1 : 1;
        dprev = b;
        ent_bit = b;
        raw_cnt++;
        model_raw(b);
      end
      p = in0;
    end
  end

  // Monitor: pops the scoreboard on handshakes, checks hold stability
  initial begin
    logic [7:0] last;
    bit pend;
    pend = 0;
    last = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (dp.data_valid) valid_cycles++;
        if (in0 || in1 || sout) strobe_cycles++;
        if (pend && dp.data_valid)
          chk("stable", dp.data_out, last);
        if (dp.data_valid && dp.data_ready) begin
          hs_cnt++;
          last_acc = dp.data_out;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word: got %0h want none", dp.data_out);
          end else begin
            chk("word", dp.data_out, exp_q.pop_front());
          end
        end
        pend = dp.data_valid && !dp.data_ready;
        last = dp.data_out;
      end else begin
        pend = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int raw0;
    int raw1;
    int n;
    int h0;
    logic [2:0] pat;

    // Reset with run held high
    rst = 1'b1; run = 1'b1; dp.data_ready = 1'b1;
    model_reset();
    cyc(2);
    chk("rst_strobes", {in0, in1, sout}, 3'b000);
    chk("rst_valid", dp.data_valid, 1'b0);
    chk("rst_data", dp.data_out, 8'h00);
    chk("rst_hf", hf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("first_strobe", {in0, in1}, 2'b11);

    // Strobe timing over two raw-bit periods
    for (int i = 0; i < 22; i++) begin
      pat = (i % 11 < 4) ? 3'b110 : (i % 11 < 8) ? 3'b000 : 3'b001;
      chk("strobe_seq", {in0, in1, sout}, pat);
      cyc(1);
    end

    // Random bits with random backpressure
    for (int i = 0; i < 1500; i++) begin
      dp.data_ready = ($urandom % 4) != 0;
      cyc(1);
    end
    dp.data_ready = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 100 && busy; i++) cyc(1);
    cyc(3);
    chk("rand_idle", busy, 1'b0);
    chk("rand_drain", exp_q.size(), 0);

    // Pattern 0,1,1,0 x4 -> 0xAA
    rst = 1'b1; model_reset(); add_aa();
    cyc(2);
    raw0 = raw_cnt; valid_cycles = 0; h0 = hs_cnt;
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 400 && (raw_cnt - raw0) < 16; i++) cyc(1);
    run = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc(1);
    cyc(3);
    chk("aa_raw", raw_cnt - raw0, 16);
    chk("aa_word", last_acc, 8'hAA);
    chk("aa_valid_cycles", valid_cycles, 1);
    chk("aa_words", hs_cnt - h0, 1);

    // Backpressure: 32 raw bits of 1,0 pairs with ready low
    rst = 1'b1; model_reset(); dp.data_ready = 1'b0;
    repeat (16) begin
      script_q.push_back(1'b1);
      script_q.push_back(1'b0);
    end
    cyc(2);
    raw0 = raw_cnt; h0 = hs_cnt;
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 800 && (raw_cnt - raw0) < 32; i++) cyc(1);
    cyc(15);
    chk("bp_valid", dp.data_valid, 1'b1);
    chk("bp_word", dp.data_out, 8'hFF);
    chk("bp_busy_hold", busy, 1'b1);
    strobe_cycles = 0; raw1 = raw_cnt;
    cyc(20);
    chk("bp_strobes_off", strobe_cycles, 0);
    chk("bp_no_sample", raw_cnt - raw1, 0);
    dp.data_ready = 1'b1;
    for (int i = 0; i < 40 && raw_cnt == raw1; i++) cyc(1);
    chk("bp_resume", raw_cnt > raw1, 1'b1);
    run = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc(1);
    cyc(3);
    chk("bp_words", hs_cnt - h0, 2);
    chk("bp_last", last_acc, 8'hFF);
    chk("bp_drain", exp_q.size(), 0);

    // Health: constant ones trip the repetition test
    rst = 1'b1; model_reset();
    repeat (20) script_q.push_back(1'b1);
    cyc(2);
    script_q.delete();
    repeat (20) script_q.push_back(1'b1);
    raw0 = raw_cnt; valid_cycles = 0;
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 400 && (raw_cnt - raw0) < 16; i++) cyc(1);
    chk("h_not_early", hf, 1'b0);
    for (int i = 0; i < 30 && !hf; i++) cyc(1);
    chk("h_fail", hf, 1'b1);
    chk("h_idle", busy, 1'b0);
    chk("h_model", hf, m_fail);
    cyc(30);
    chk("h_no_sample", raw_cnt - raw0, 16);
    chk("h_no_valid", valid_cycles, 0);
    run = 1'b0;
    cyc(5);
    chk("h_sticky", hf, 1'b1);
    rst = 1'b1; model_reset(); script_q.delete();
    cyc(1);
    chk("h_cleared", hf, 1'b0);

    // Drop run during RESOLVE: capture completes, then idle
    cyc(1);
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 20 && !in0; i++) cyc(1);
    for (int i = 0; i < 20 && in0; i++) cyc(1);
    run = 1'b0; raw1 = raw_cnt; n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      cyc(1);
      if (sout) n++;
    end
    chk("stop_cap_cycles", n, 3);
    chk("stop_idle", busy, 1'b0);
    cyc(20);
    chk("stop_no_sample", raw_cnt - raw1, 0);

    // Reset during CAPTURE loses the partial word
    run = 1'b1;
    raw1 = raw_cnt;
    for (int i = 0; i < 200 && (raw_cnt - raw1) < 5; i++) cyc(1);
    for (int i = 0; i < 20 && !sout; i++) cyc(1);
    chk("cap_reached", sout, 1'b1);
    rst = 1'b1; model_reset(); add_aa();
    cyc(1);
    chk("cap_rst_out",
        {in0, in1, sout, dp.data_valid, busy, hf}, 6'b0);
    chk("cap_rst_data", dp.data_out, 8'h00);
    raw0 = raw_cnt; h0 = hs_cnt;
    rst = 1'b0;
    for (int i = 0; i < 400 && (raw_cnt - raw0) < 16; i++) cyc(1);
    run = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc(1);
    cyc(3);
    chk("cap_rst_word", last_acc, 8'hAA);
    chk("cap_rst_words", hs_cnt - h0, 1);
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
